tmds_encoder_hdmi: RTL

Multi-channel, pipelined TMDS encoder for the HDMI output path of the debug display. It generalises the single-channel DVI encoder to CHANNELS lanes with four modes: control, video, TERC4 data island and guard band. Each lane keeps its own running DC bias. The block sits between the timing/pixel generator and the 10:1 serialisers.

---
 rtl/tmds_encoder_hdmi.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tmds_encoder_hdmi.sv
// tmds_encoder_hdmi: CHANNELS-lane TMDS encoder for HDMI (control, video,
// TERC4 data island, guard band), two-stage pipeline, per-lane DC bias.
// Optional feature macro: TMDS_TERC4_EN enables data-island (TERC4) symbols
// and data-island guard bands. Without it mode 10 encodes as control and
// guard mode always emits video guard bands.

package tmds_encoder_hdmi_pkg;
  typedef enum logic [1:0] {
    M_CTRL = 2'b00,
    M_VID  = 2'b01,
    M_DI   = 2'b10,
    M_GRD  = 2'b11
  } mode_e;

  localparam logic [9:0] SYM_CTRL0 = 10'b1101010100;
  localparam logic [9:0] SYM_CTRL1 = 10'b0010101011;
  localparam logic [9:0] SYM_CTRL2 = 10'b0101010100;
  localparam logic [9:0] SYM_CTRL3 = 10'b1010101011;
  localparam logic [9:0] SYM_GRD_A = 10'b1011001100;
  localparam logic [9:0] SYM_GRD_B = 10'b0100110011;
endpackage

// Per-lane encoder: stage-1 q_m/balance, stage-2 symbol select and bias.
module tmds_encoder_hdmi_lane
  import tmds_encoder_hdmi_pkg::*;
#(
  parameter int ROLE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  mode_e      i_mode_s1,
`ifdef TMDS_TERC4_EN
  input  logic       i_guard_di_s1,
  input  logic [3:0] i_aux,
`endif
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  output logic [9:0] o_tmds,
  output logic [4:0] o_bias
);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // XNOR when the byte is ones-heavy (ties broken by d[0]=0), else XOR.
  function automatic logic [8:0] qm_enc(input logic [7:0] d);
    logic [3:0] n1;
    logic       xn;
    logic [8:0] q;
    n1   = ones8(d);
    xn   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return SYM_CTRL0;
      2'b01:   return SYM_CTRL1;
      2'b10:   return SYM_CTRL2;
      default: return SYM_CTRL3;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4(input logic [3:0] a);
    case (a)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  logic [3:0] aux_q;
`endif

  logic [8:0]        qm_d, qm_q;
  logic signed [4:0] bal_d, bal_q;
  logic [1:0]        ctrl_q;
  logic [9:0]        tmds_d, tmds_q, tmds_v;
  logic signed [4:0] bias_d, bias_q, bias_v;
  logic              q8;

  // Balance of q_m[7:0]: 2*ones - 8, wraps correctly in 5-bit two's complement.
  always_comb begin
    qm_d  = qm_enc(i_data);
    bal_d = {ones8(qm_d[7:0]), 1'b0} - 5'd8;
  end

  // Stage 1: register q_m, balance and the lane's control bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      qm_q   <= '0;
      bal_q  <= '0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_d;
      bal_q  <= bal_d;
      ctrl_q <= i_ctrl;
    end
  end

`ifdef TMDS_TERC4_EN
  // Stage 1: register the TERC4 nibble alongside the rest of the symbol.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) aux_q <= '0;
    else          aux_q <= i_aux;
  end
`endif

  // Video symbol and bias update, steering the running disparity toward 0.
  always_comb begin
    q8 = qm_q[8];
    if ((bias_q == 5'sd0) || (bal_q == 5'sd0)) begin
      tmds_v = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
      bias_v = q8 ? (bias_q + bal_q) : (bias_q - bal_q);
    end else if (bias_q[4] == bal_q[4]) begin
      tmds_v = {1'b1, q8, ~qm_q[7:0]};
      bias_v = bias_q + {3'b000, q8, 1'b0} - bal_q;
    end else begin
      tmds_v = {1'b0, q8, qm_q[7:0]};
      bias_v = bias_q - {3'b000, ~q8, 1'b0} + bal_q;
    end
  end

  // Stage 2 select: every non-video symbol clears the bias.
  always_comb begin
    tmds_d = ctrl_sym(ctrl_q);
    bias_d = '0;
    case (i_mode_s1)
      M_VID: begin
        tmds_d = tmds_v;
        bias_d = bias_v;
      end
      M_GRD: begin
        tmds_d = (ROLE == 1) ? SYM_GRD_B : SYM_GRD_A;
`ifdef TMDS_TERC4_EN
        if (i_guard_di_s1) tmds_d = (ROLE == 0) ? terc4(aux_q) : SYM_GRD_B;
`endif
      end
`ifdef TMDS_TERC4_EN
      M_DI:    tmds_d = terc4(aux_q);
`endif
      default: tmds_d = ctrl_sym(ctrl_q);
    endcase
  end

  // Stage 2: output symbol and running bias.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmds_q <= SYM_CTRL0;
      bias_q <= '0;
    end else begin
      tmds_q <= tmds_d;
      bias_q <= bias_d;
    end
  end

  assign o_tmds = tmds_q;
  assign o_bias = bias_q;

endmodule

// Top: shared stage-1 mode/guard-type registers plus an array of lanes.
module tmds_encoder_hdmi
  import tmds_encoder_hdmi_pkg::*;
#(
  parameter int CHANNELS = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              i_mode,
  input  logic [8*CHANNELS-1:0]   i_data,
  input  logic [2*CHANNELS-1:0]   i_ctrl,
  input  logic [4*CHANNELS-1:0]   i_aux,
  output logic [10*CHANNELS-1:0]  o_tmds,
  output logic [5*CHANNELS-1:0]   o_bias
);

  mode_e mode_d, mode_q;

  // Mode decode; without TERC4 the data-island code folds onto control.
  always_comb begin
    mode_d = mode_e'(i_mode);
`ifndef TMDS_TERC4_EN
    if (mode_d == M_DI) mode_d = M_CTRL;
`endif
  end

  // Stage 1: shared mode register, forced to control on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mode_q <= M_CTRL;
    else          mode_q <= mode_d;
  end

`ifdef TMDS_TERC4_EN
  logic guard_di_q;

  // Stage 1: guard type comes from lane 0 ctrl bit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) guard_di_q <= 1'b0;
    else          guard_di_q <= i_ctrl[0];
  end
`else
  logic unused_aux;
  assign unused_aux = ^i_aux;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tmds_encoder_hdmi_lane #(.ROLE(c % 3)) u_lane (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_mode_s1    (mode_q),
`ifdef TMDS_TERC4_EN
      .i_guard_di_s1(guard_di_q),
      .i_aux        (i_aux[4*c +: 4]),
`endif
      .i_data       (i_data[8*c +: 8]),
      .i_ctrl       (i_ctrl[2*c +: 2]),
      .o_tmds       (o_tmds[10*c +: 10]),
      .o_bias       (o_bias[5*c +: 5])
    );
  end

endmodule
